// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit single-cycle core: datapath widths,
// register-file size and the status-flag layout {zero, carry, neg}.
package core_pkg;

  localparam int CORE_DATA_W   = 8;
  localparam int CORE_NUM_REGS = 4;
  localparam int CORE_ADDR_W   = 2;

  // Flag word, MSB first: zero, carry, neg.
  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
  } flags_t;

  // After reset the core behaves as if the last result was zero.
  localparam flags_t FLAGS_RST = '{zero: 1'b1, carry: 1'b0, neg: 1'b0};

  // True when addr selects an implemented register.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned num);
    return (addr < num);
  endfunction

endpackage

// File: rtl/status_reg.sv
// Status-flag register: three flag flops with a shared load enable.
module status_reg
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [2:0] i_flags,
  output logic [2:0] o_flags
);

  flags_t r_flags;

  // Load all three flags together when enabled, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= FLAGS_RST;
    end else if (i_load) begin
      r_flags <= i_flags;
    end else begin
      r_flags <= r_flags;
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/reg_bank.sv
// General-purpose register file with two asynchronous read ports, one
// write port and the status-flag register. Reads never bypass a pending
// write, so the read-to-ALU-to-write path stays free of combinational loops.
module reg_bank
  import core_pkg::*;
#(
  parameter int                DATA_W   = CORE_DATA_W,
  parameter int                NUM_REGS = CORE_NUM_REGS,
  parameter int                ADDR_W   = CORE_ADDR_W,
  parameter logic [DATA_W-1:0] RST_VAL  = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              zero_in,
  input  logic              carry_in,
  input  logic              neg_in,
  output logic              zero_q,
  output logic              carry_q,
  output logic              neg_q,
  output logic              wr_err
);

  logic [DATA_W-1:0] w_regs [NUM_REGS];
  logic              w_wr_valid;
  logic              w_rd_a_valid;
  logic              w_rd_b_valid;
  logic              r_wr_err;
  flags_t            w_flags_in;
  flags_t            w_flags_q;

  assign w_wr_valid   = addr_in_range(32'(wr_addr), NUM_REGS);
  assign w_rd_a_valid = addr_in_range(32'(rd_addr_a), NUM_REGS);
  assign w_rd_b_valid = addr_in_range(32'(rd_addr_b), NUM_REGS);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic              w_hit;
    logic [DATA_W-1:0] r_q;

    assign w_hit = wr_en && (wr_addr == ADDR_W'(g));

    // One enabled flop per register; out-of-range addresses never match.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= RST_VAL;
      end else if (w_hit) begin
        r_q <= wr_data;
      end else begin
        r_q <= r_q;
      end
    end

    assign w_regs[g] = r_q;
  end

  // Read port A: current register contents, zero for unimplemented addresses.
  always_comb begin
    rd_data_a = {DATA_W{1'b0}};
    if (w_rd_a_valid) begin
      rd_data_a = w_regs[rd_addr_a];
    end else begin
      rd_data_a = {DATA_W{1'b0}};
    end
  end

  // Read port B: same selection as port A.
  always_comb begin
    rd_data_b = {DATA_W{1'b0}};
    if (w_rd_b_valid) begin
      rd_data_b = w_regs[rd_addr_b];
    end else begin
      rd_data_b = {DATA_W{1'b0}};
    end
  end

  // Sticky error: set by any write to an unimplemented address, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else if (wr_en && !w_wr_valid) begin
      r_wr_err <= 1'b1;
    end else begin
      r_wr_err <= r_wr_err;
    end
  end

  assign wr_err = r_wr_err;

  assign w_flags_in = '{zero: zero_in, carry: carry_in, neg: neg_in};

  status_reg u_status (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (flag_we),
    .i_flags (w_flags_in),
    .o_flags (w_flags_q)
  );

  assign zero_q  = w_flags_q.zero;
  assign carry_q = w_flags_q.carry;
  assign neg_q   = w_flags_q.neg;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: a 4-register instance and a 3-register instance
// share all inputs; a reference model pushes expected results onto a
// queue when each step is driven and pops them after the clock edge.
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [7:0] wr_data;
  logic       wr_en, flag_we, zero_in, carry_in, neg_in;

  logic [7:0] a4, b4, a3, b3;
  logic       z4, c4, n4, e4, z3, c3, n3, e3;

  typedef struct {
    logic [7:0] a4, b4, a3, b3;
    logic [2:0] fl;
    logic       err3;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m4 [4];
  logic [7:0] m3 [4];
  logic [2:0] mfl;
  logic       me3;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  reg_bank dut (
    .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a4), .rd_data_b(b4), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flag_we(flag_we), .zero_in(zero_in), .carry_in(carry_in),
    .neg_in(neg_in), .zero_q(z4), .carry_q(c4), .neg_q(n4), .wr_err(e4)
  );

  reg_bank #(.NUM_REGS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a3), .rd_data_b(b3), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flag_we(flag_we), .zero_in(zero_in), .carry_in(carry_in),
    .neg_in(neg_in), .zero_q(z3), .carry_q(c3), .neg_q(n3), .wr_err(e3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] m3rd(input logic [1:0] a);
    return (a < 2'd3) ? m3[a] : 8'h00;
  endfunction

  task automatic check_now(input string pfx, input exp_t e);
    chk({pfx, "_a4"}, a4, e.a4);
    chk({pfx, "_b4"}, b4, e.b4);
    chk({pfx, "_a3"}, a3, e.a3);
    chk({pfx, "_b3"}, b3, e.b3);
    chk({pfx, "_fl4"}, 8'({z4, c4, n4}), 8'(e.fl));
    chk({pfx, "_fl3"}, 8'({z3, c3, n3}), 8'(e.fl));
    chk({pfx, "_err4"}, 8'(e4), 8'h00);
    chk({pfx, "_err3"}, 8'(e3), 8'(e.err3));
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.a4   = m4[rd_addr_a];
    e.b4   = m4[rd_addr_b];
    e.a3   = m3rd(rd_addr_a);
    e.b3   = m3rd(rd_addr_b);
    e.fl   = mfl;
    e.err3 = me3;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m4[i] = 8'h00;
      m3[i] = 8'h00;
    end
    mfl = 3'b100;
    me3 = 1'b0;
  endtask

  // One clocked operation: drive, check no-bypass reads, push expectation, edge, pop and compare.
  task automatic step(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                      input logic fwe, input logic [2:0] fin,
                      input logic [1:0] ra, input logic [1:0] rb, input string tag);
    exp_t e;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; flag_we = fwe;
    {zero_in, carry_in, neg_in} = fin;
    rd_addr_a = ra; rd_addr_b = rb;
    #1;
    check_now({tag, "_pre"}, model_view());
    if (we) begin
      m4[wa] = wd;
      if (wa < 2'd3) m3[wa] = wd;
      else me3 = 1'b1;
    end
    if (fwe) mfl = fin;
    q.push_back(model_view());
    @(posedge clk);
    #1;
    wr_en = 1'b0; flag_we = 1'b0;
    e = q.pop_front();
    check_now({tag, "_post"}, e);
  endtask

  // Reset asserted mid-cycle while a write and flag load are being presented.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h5A; flag_we = 1'b1;
    {zero_in, carry_in, neg_in} = 3'b011;
    rd_addr_a = 2'd2; rd_addr_b = 2'd1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now({tag, "_now"}, model_view());
    @(posedge clk);
    #1;
    check_now({tag, "_edge"}, model_view());
    @(negedge clk);
    wr_en = 1'b0; flag_we = 1'b0; rst_n = 1'b1;
    #1;
    check_now({tag, "_rel"}, model_view());
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; flag_we = 1'b0;
    zero_in = 1'b0; carry_in = 1'b0; neg_in = 1'b0;
    rd_addr_a = 2'd0; rd_addr_b = 2'd3;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_now("reset", model_view());
    rst_n = 1'b1;

    // Write then read back with no bypass, old value visible before the edge.
    step(1'b1, 2'd1, 8'h11, 1'b0, 3'b000, 2'd1, 2'd0, "t2_seed");
    step(1'b1, 2'd1, 8'h3C, 1'b0, 3'b000, 2'd1, 2'd1, "t2_wr");

    // Compare-only op loads flags, then flags hold with flag_we low.
    step(1'b0, 2'd1, 8'hEE, 1'b1, 3'b011, 2'd1, 2'd0, "t3_load");
    step(1'b0, 2'd1, 8'hEE, 1'b0, 3'b100, 2'd1, 2'd0, "t3_hold");

    // Consecutive writes, then distinct and identical read addresses.
    step(1'b1, 2'd0, 8'h01, 1'b0, 3'b000, 2'd0, 2'd3, "t4_r0");
    step(1'b1, 2'd3, 8'hFF, 1'b0, 3'b000, 2'd0, 2'd3, "t4_r3");
    step(1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 2'd3, 2'd3, "t4_same");

    // Write and flag load on the same edge.
    step(1'b1, 2'd1, 8'h80, 1'b1, 3'b001, 2'd1, 2'd0, "t6_both");

    // Write r2 then reset mid-cycle.
    step(1'b1, 2'd2, 8'hA5, 1'b0, 3'b000, 2'd2, 2'd2, "t1_wr");
    mid_reset("t1_rst");

    // Out-of-range write on the 3-register instance: no change, sticky error.
    step(1'b1, 2'd3, 8'h77, 1'b0, 3'b000, 2'd3, 2'd2, "t5_wr");
    step(1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 2'd3, 2'd0, "t5_sticky");
    step(1'b1, 2'd0, 8'h42, 1'b0, 3'b000, 2'd3, 2'd0, "t5_valid");

    // Mixed traffic across all addresses.
    for (int i = 0; i < 16; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "rnd");
    end

    mid_reset("final_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
